// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame engine.
// Optional build macro: UART_TX_STICKY_PARITY_EN (mark/space parity).
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    localparam int DW_MIN = 5;
    localparam int DW_MAX = 9;

endpackage

// File: rtl/uart_tx_parity_gen.sv
// Combinational parity bit from the captured frame word and parity mode.
// UART_TX_STICKY_PARITY_EN adds mark/space; otherwise only PAR_TYP[0] counts.
module uart_tx_parity_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_par_typ,
    output logic                  o_parity
);

    logic w_even;
    assign w_even = ^i_data;

`ifdef UART_TX_STICKY_PARITY_EN
    // Full four-mode decode including the sticky mark/space codes.
    always_comb begin
        o_parity = w_even;
        unique case (i_par_typ)
            PAR_EVEN:  o_parity = w_even;
            PAR_ODD:   o_parity = ~w_even;
            PAR_MARK:  o_parity = 1'b1;
            PAR_SPACE: o_parity = 1'b0;
        endcase
    end
`else
    // Mode bit 1 is don't-care: 10 acts as even, 11 as odd.
    logic w_unused;
    assign w_unused = i_par_typ[1];

    // Even/odd selection from the low mode bit only.
    always_comb begin
        o_parity = (i_par_typ[0] == PAR_ODD[0]) ? ~w_even : w_even;
    end
`endif

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start, DATA_WIDTH bits LSB first, optional
// parity, one or two stop bits. Macro: UART_TX_STICKY_PARITY_EN.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_bad_width
        $error("uart_tx_frame: DATA_WIDTH out of range");
    end

    tx_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_stop_cnt;
    logic                  r_par_en;
    logic [1:0]            r_par_typ;
    logic                  r_stop2;

    logic w_parity;
    logic w_stop_last;
    logic w_accept;

    uart_tx_parity_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .i_data   (r_data),
        .i_par_typ(r_par_typ),
        .o_parity (w_parity)
    );

    // Last stop cycle; a new word may be taken on that edge for zero gap.
    always_comb begin
        w_stop_last = !r_stop2 || r_stop_cnt;
        w_accept    = Data_Valid &&
                      ((r_state == IDLE) ||
                       ((r_state == STOP) && w_stop_last));
    end

    // Frame FSM with registered line and busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
            r_data     <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_stop_cnt <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_typ  <= PAR_EVEN;
            r_stop2    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
                START: begin
                    TX_OUT  <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_cnt   <= '0;
                    r_state <= DATA;
                end
                DATA: begin
                    if (r_cnt == LAST) begin
                        r_stop_cnt <= 1'b0;
                        if (r_par_en) begin
                            TX_OUT  <= w_parity;
                            r_state <= PARITY;
                        end else begin
                            TX_OUT  <= 1'b1;
                            r_state <= STOP;
                        end
                    end else begin
                        TX_OUT  <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    TX_OUT     <= 1'b1;
                    r_stop_cnt <= 1'b0;
                    r_state    <= STOP;
                end
                STOP: begin
                    TX_OUT <= 1'b1;
                    if (w_stop_last) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase

            if (w_accept) begin
                r_data    <= P_DATA;
                r_shift   <= P_DATA;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_stop2   <= STOP2;
                TX_OUT    <= 1'b0;
                busy      <= 1'b1;
                r_state   <= START;
            end
        end
    end

endmodule
